// File: rtl/regfile_multiport.sv
// Multi-port integer register file: NREAD combinational reads, writeback and link write ports,
// hardwired zero register and a pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int LINK_REG = DEPTH - 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             RegWrite,
  input  logic [$clog2(DEPTH)-1:0]         WriteRegister,
  input  logic [WIDTH-1:0]                 WriteData,
  input  logic                             blink_sig,
  input  logic [WIDTH-1:0]                 link_register,
  input  logic                             IssueValid,
  input  logic [$clog2(DEPTH)-1:0]         IssueRegister,
  input  logic [NREAD*$clog2(DEPTH)-1:0]   ReadRegister,
  output logic [NREAD*WIDTH-1:0]           ReadData,
  output logic [NREAD-1:0]                 Busy,
  output logic                             Stall
);

  localparam int AW = $clog2(DEPTH);
`ifdef REGFILE_BYPASS_EN
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);
      if (gi == ZERO_REG) begin : g_zero
        assign regs[gi]    = '0;
        assign pending[gi] = 1'b0;
      end else begin : g_store
        logic [WIDTH-1:0] data_reg;
        logic             pend_reg;
        logic             wb_hit;
        logic             link_hit;
        logic             issue_hit;

        assign wb_hit    = RegWrite && (WriteRegister == IDX);
        assign link_hit  = blink_sig && (gi == LINK_REG);
        assign issue_hit = IssueValid && (IssueRegister == IDX);

        // Link beats writeback on data; a new issue beats any retiring write on pending.
        always_ff @(posedge clk) begin
          if (reset) begin
            data_reg <= '0;
            pend_reg <= 1'b0;
          end else begin
            if (link_hit)
              data_reg <= link_register;
            else if (wb_hit)
              data_reg <= WriteData;

            if (issue_hit)
              pend_reg <= 1'b1;
            else if (wb_hit || link_hit)
              pend_reg <= 1'b0;
          end
        end

        assign regs[gi]    = data_reg;
        assign pending[gi] = pend_reg;
      end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      logic             busy;

      assign addr = ReadRegister[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic wb_fwd;
      logic link_fwd;

      assign link_fwd = blink_sig && (addr == LINK_IDX) && (addr != ZERO_IDX);
      assign wb_fwd   = RegWrite && (addr == WriteRegister) && (addr != ZERO_IDX);

      always_comb begin
        data = regs[addr];
        busy = pending[addr];
        if (link_fwd) begin
          data = link_register;
          busy = 1'b0;
        end else if (wb_fwd) begin
          data = WriteData;
          busy = 1'b0;
        end
      end
`else
      assign data = regs[addr];
      assign busy = pending[addr];
`endif
      assign ReadData[gi*WIDTH +: WIDTH] = data;
      assign Busy[gi]                    = busy;
    end
  endgenerate

  assign Stall = |Busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: behavioural array model checked every cycle, plus directed
// literal expectations and a randomized phase.
module tb_regfile_multiport;
  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int ZR    = 31;
  localparam int LR    = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   RegWrite;
  logic [AW-1:0]          WriteRegister;
  logic [WIDTH-1:0]       WriteData;
  logic                   blink_sig;
  logic [WIDTH-1:0]       link_register;
  logic                   IssueValid;
  logic [AW-1:0]          IssueRegister;
  logic [NREAD*AW-1:0]    ReadRegister;
  logic [NREAD*WIDTH-1:0] ReadData;
  logic [NREAD-1:0]       Busy;
  logic                   Stall;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .blink_sig(blink_sig), .link_register(link_register),
    .IssueValid(IssueValid), .IssueRegister(IssueRegister),
    .ReadRegister(ReadRegister), .ReadData(ReadData), .Busy(Busy), .Stall(Stall)
  );

  // Behavioural model: plain arrays updated with the architectural rules, in priority order.
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit               model_pend [DEPTH];
  bit               model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[i]  = '0;
        model_pend[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (RegWrite && WriteRegister != ZR) model_mem[WriteRegister] = WriteData;
      if (blink_sig) model_mem[LR] = link_register;
      if (RegWrite) model_pend[WriteRegister] = 1'b0;
      if (blink_sig) model_pend[LR] = 1'b0;
      if (IssueValid && IssueRegister != ZR) model_pend[IssueRegister] = 1'b1;
    end
  end

  // Single compare process: every port, every cycle once the model state is known.
  always @(negedge clk) begin
    if (model_valid) begin
      logic             exp_stall;
      exp_stall = 1'b0;
      for (int k = 0; k < NREAD; k++) begin
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] exp_d;
        logic             exp_b;
        a     = ReadRegister[k*AW +: AW];
        exp_d = (a == ZR) ? '0 : model_mem[a];
        exp_b = model_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (a != ZR) begin
          if (blink_sig && a == LR) begin
            exp_d = link_register;
            exp_b = 1'b0;
          end else if (RegWrite && a == WriteRegister) begin
            exp_d = WriteData;
            exp_b = 1'b0;
          end
        end
`endif
        exp_stall = exp_stall | exp_b;
        n_checks++;
        if (ReadData[k*WIDTH +: WIDTH] !== exp_d || Busy[k] !== exp_b) begin
          n_fail++;
          $display("FAIL model_port%0d t=%0t addr=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   k, $time, a, ReadData[k*WIDTH +: WIDTH], Busy[k], exp_d, exp_b);
        end
      end
      n_checks++;
      if (Stall !== exp_stall) begin
        n_fail++;
        $display("FAIL model_stall t=%0t: got %b, expected %b", $time, Stall, exp_stall);
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic idle();
    reset = 1'b0; RegWrite = 1'b0; blink_sig = 1'b0; IssueValid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    ReadRegister = {p1, p0};
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] r, input logic [WIDTH-1:0] d);
    RegWrite = 1'b1; WriteRegister = r; WriteData = d;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(27, 31));
    return AW'($urandom_range(0, 31));
  endfunction

  localparam logic [WIDTH-1:0] PAT = 64'h0000010204080001;

  initial begin
    idle();
    reset = 1'b1;
    WriteRegister = '0; WriteData = '0; link_register = '0; IssueRegister = '0;
    rd(0, 1);
    edge_step();
    edge_step();
    idle();
    @(negedge clk);
    chk("reset_rd0", ReadData[63:0], 64'h0);
    chk("reset_busy", {62'b0, Busy}, 64'h0);
    chk("reset_stall", {63'b0, Stall}, 64'h0);

    // Zero register ignores writes and issues.
    wr(31, 64'hA0); rd(31, 31);
    edge_step();
    idle(); IssueValid = 1'b1; IssueRegister = 31;
    edge_step();
    idle();
    @(negedge clk);
    chk("zero_rd", ReadData[63:0], 64'h0);
    chk("zero_busy", {62'b0, Busy}, 64'h0);

    // Pattern fill 0..30, each read back on both ports the cycle after its write.
    for (int i = 0; i < 31; i++) begin
      wr(AW'(i), PAT * i);
      edge_step();
      idle(); rd(AW'(i), AW'(i));
      @(negedge clk);
      chk($sformatf("pat_r%0d_p0", i), ReadData[63:0], PAT * i);
      chk($sformatf("pat_r%0d_p1", i), ReadData[127:64], PAT * i);
      edge_step();
    end
    rd(31, 31);
    @(negedge clk);
    chk("pat_r31", ReadData[63:0], 64'h0);

    // Link port wins a same-cycle collision on LINK_REG.
    edge_step();
    wr(30, 64'h1111); blink_sig = 1'b1; link_register = 64'h2222;
    edge_step();
    idle(); rd(30, 30);
    @(negedge clk);
    chk("link_conflict", ReadData[63:0], 64'h2222);

    // Scoreboard set, clear, and set-wins-over-clear.
    edge_step();
    IssueValid = 1'b1; IssueRegister = 5;
    edge_step();
    idle(); rd(5, 0);
    @(negedge clk);
    chk("sb_busy_after_issue", {63'b0, Busy[0]}, 64'h1);
    chk("sb_stall_after_issue", {63'b0, Stall}, 64'h1);
    edge_step();
    wr(5, 64'h55);
    edge_step();
    idle();
    @(negedge clk);
    chk("sb_busy_after_write", {63'b0, Busy[0]}, 64'h0);
    chk("sb_data_after_write", ReadData[63:0], 64'h55);
    edge_step();
    wr(5, 64'h56); IssueValid = 1'b1; IssueRegister = 5;
    edge_step();
    idle();
    @(negedge clk);
    chk("sb_set_wins", {63'b0, Busy[0]}, 64'h1);
    edge_step();

    // Same-cycle read of a register being written (7 is pending with 0x70 stored).
    wr(7, 64'h70); IssueValid = 1'b1; IssueRegister = 7;
    edge_step();
    idle(); wr(7, 64'h77); rd(7, 7);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", ReadData[63:0], 64'h77);
    chk("bypass_busy", {63'b0, Busy[0]}, 64'h0);
`else
    chk("nobypass_data", ReadData[63:0], 64'h70);
    chk("nobypass_busy", {63'b0, Busy[0]}, 64'h1);
`endif
    edge_step();
    idle();

    // Randomized phase; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      RegWrite      = $urandom_range(0, 1);
      WriteRegister = pick_addr();
      WriteData     = {$urandom, $urandom};
      blink_sig     = ($urandom_range(0, 3) == 0);
      link_register = {$urandom, $urandom};
      IssueValid    = $urandom_range(0, 1);
      IssueRegister = pick_addr();
      rd(pick_addr(), pick_addr());
      edge_step();
    end
    idle();
    edge_step();

    // Reset mid-operation discards data and pending state.
    for (int i = 1; i <= 3; i++) begin
      wr(AW'(i), 64'h100 + i);
      edge_step();
    end
    idle(); IssueValid = 1'b1; IssueRegister = 4;
    edge_step();
    idle(); rd(4, 2);
    @(negedge clk);
    chk("pre_reset_busy4", {63'b0, Busy[0]}, 64'h1);
    chk("pre_reset_r2", ReadData[127:64], 64'h102);
    edge_step();
    reset = 1'b1;
    edge_step();
    idle(); rd(1, 2);
    @(negedge clk);
    chk("post_reset_r1", ReadData[63:0], 64'h0);
    chk("post_reset_r2", ReadData[127:64], 64'h0);
    edge_step();
    rd(3, 4);
    @(negedge clk);
    chk("post_reset_r3", ReadData[63:0], 64'h0);
    chk("post_reset_stall", {63'b0, Stall}, 64'h0);
    edge_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the CPU's integer register file. It holds DEPTH registers of WIDTH bits, with NREAD combinational read ports and two synchronous write ports: the writeback port and a dedicated link port for branch-and-link. A hardwired zero register, synchronous clear on reset, and a pending-write scoreboard are built in. The scoreboard lets the decode stage detect read-after-write hazards and stall. It sits between decode (reads, issue) and writeback (writes) in the 5-stage pipeline.

## Interface
Parameters:
- WIDTH, 64, data width of each register
- DEPTH, 32, number of registers; power of two; AW = $clog2(DEPTH)
- NREAD, 2, number of read ports
- ZERO_REG, DEPTH-1, index that always reads 0 and ignores writes
- LINK_REG, DEPTH-2, index written by the link port

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- RegWrite  in  1  writeback write enable
- WriteRegister  in  AW  writeback destination
- WriteData  in  WIDTH  writeback data
- blink_sig  in  1  link write enable
- link_register  in  WIDTH  link data, written to LINK_REG
- IssueValid  in  1  marks IssueRegister pending (instruction issued with a destination)
- IssueRegister  in  AW  destination of the issued instruction
- ReadRegister  in  NREAD*AW  packed read addresses; port k is bits [k*AW +: AW]
- ReadData  out  NREAD*WIDTH  packed read data; port k is bits [k*WIDTH +: WIDTH]
- Busy  out  NREAD  per read port: the addressed register has a write outstanding
- Stall  out  1  OR of all Busy bits

## Operation
- Storage: registers 0..DEPTH-1, except ZERO_REG, which has no storage.
  - ReadData for ZERO_REG is always 0.
  - Writes and issues targeting ZERO_REG are ignored.
- Writeback port: if RegWrite=1, register[WriteRegister] <= WriteData on the clock edge.
- Link port: if blink_sig=1, register[LINK_REG] <= link_register on the clock edge.
- Simultaneous RegWrite and blink_sig to LINK_REG in the same cycle: the link port wins.
- Scoreboard: one pending bit per register.
  - IssueValid sets pending[IssueRegister].
  - RegWrite clears pending[WriteRegister].
  - blink_sig clears pending[LINK_REG].
  - A set and a clear on the same register in the same cycle: set wins, because the new producer supersedes the retiring one.
  - pending[ZERO_REG] is constant 0.
- Reads are combinational from current register state: ReadData[k] = register[ReadRegister[k]].
- Busy[k] = pending[ReadRegister[k]]. Stall = |Busy.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Reset (reset=1 at a clock edge) clears all registers to 0 and all pending bits to 0.
  - Reset overrides writes and issues in the same cycle.
  - After reset: ReadData=0, Busy=0, Stall=0.
- Write latency is one edge: data written at edge N is visible on ReadData after edge N.
- Issue latency is one edge: Busy asserts from the cycle after IssueValid.
- A clear takes effect at the same edge as the data write, so Busy drops exactly when the new value becomes readable.
- Reset asserted mid-sequence discards all outstanding pending state. There is no recovery of in-flight writes.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-through forwarding.
  - If ReadRegister[k] matches a register being written this cycle, ReadData[k] returns the incoming data, with link data taking priority when LINK_REG is hit by both ports.
  - Busy[k] is forced to 0 for that port.
  - ZERO_REG is never bypassed.
- Not defined: reads see only stored state, and Busy reflects pending bits unchanged.

## Test plan
- Zero register: RegWrite=1, WriteRegister=31, WriteData=0xA0 -> ReadData on port 0 addressing 31 is 0. A following issue to 31 leaves Busy=0.
- Pattern: write i*0x0000010204080001 to each register 0..30 -> each read on both ports returns its value the cycle after its write. Register 31 reads 0.
- Link conflict: RegWrite to 30 with 0x1111 and blink_sig with 0x2222 in the same cycle -> register 30 reads 0x2222.
- Scoreboard: IssueValid for register 5, then read 5 -> Busy[0]=1 and Stall=1 the next cycle. RegWrite to 5 with 0x55 -> Busy=0 and ReadData=0x55 after the edge. Issue and write to 5 in the same cycle -> Busy stays 1.
- Bypass (REGFILE_BYPASS_EN): read 7 while writing 0x77 to 7 -> ReadData=0x77 and Busy=0 in the same cycle. Without the macro -> old value is returned.
- Reset mid-operation: registers 1..3 written and register 4 pending, then reset=1 for one edge -> all reads return 0 and Stall=0.
